perf_event_counter_bank: RTL and testbench
==========================================

Name: perf_event_counter_bank

Overview:
Parametrised multi-channel successor to the single instruction counter in the or1200 performance-monitor subsystem. NUM_CH independent event counters share one start/end control FSM. Each channel has a run-time counting mode (level, rising-edge, ungated level), wrap or saturate arithmetic and a sticky overflow flag. End-of-run snapshots are read through a registered select port, so software-facing logic needs one read mux instead of NUM_CH wide buses.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
CNT_W, 64, counter and snapshot width in bits (8..64)
SEL_W, 2, read-select width; must be >= clog2(NUM_CH), minimum 1
SATURATE, 0, 0 = counters wrap to 0 past all-ones; 1 = counters hold at all-ones

Ports:
clk  input  1  clock; all logic is posedge
rst  input  1  asynchronous reset, active-high
en  input  1  global count enable
stall  input  1  pipeline freeze (id_freeze equivalent); gates modes 01 and 10
perf_start  input  1  pulse: clear everything and begin a run
perf_end  input  1  pulse: end the run and capture snapshots
event_in  input  NUM_CH  per-channel event lines
ch_mode  input  2*NUM_CH  per-channel mode; bits [2i+1:2i] belong to channel i
rd_sel  input  SEL_W  channel index for readout
rd_live  input  1  1 = read the live counter; 0 = read the snapshot
rd_data  output  CNT_W  registered readout
busy  output  1  high in RUN
done  output  1  high in DONE
ovf  output  NUM_CH  sticky per-channel overflow flags

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all live counters, snapshots, ovf, rd_data and edge registers = 0.
  - busy=0, done=0.
- FSM states: IDLE, RUN, DONE.
  - Any state + perf_start -> RUN. Live counters, snapshots and ovf clear on the same edge.
  - RUN + perf_end (with perf_start low) -> DONE. Each snapshot[i] <= live[i] as registered before this edge. The increment for that cycle is discarded.
  - perf_end in IDLE or DONE: ignored.
  - perf_start and perf_end in the same cycle: perf_start wins.
  - No other transitions. DONE holds until the next perf_start.
- Per-channel increment condition inc[i], evaluated only in RUN, only with en=1, and never in a perf_start or perf_end cycle:
  - mode 00: channel off.
  - mode 01: event_in[i] & !stall.
  - mode 10: event_in[i] & !prev[i] & !stall, where prev[i] is a register tracking event_in[i] every cycle in all states. A rising edge that occurs during stall is lost.
  - mode 11: event_in[i], stall ignored.
  - ch_mode changes take effect on the next cycle. No mid-run clearing.
- Arithmetic, on inc[i] with live[i] == all-ones:
  - ovf[i] <= 1, sticky until perf_start or reset.
  - Counter goes to 0 if SATURATE=0, or holds all-ones if SATURATE=1.
  - Otherwise live[i] <= live[i]+1.
  - Increment is at most 1 per cycle.
- Outputs: busy = (state==RUN); done = (state==DONE); both decoded directly from the state register.
- Readout, latency 1 cycle:
  - rd_data <= rd_live ? live[rd_sel] : snapshot[rd_sel].
  - rd_sel >= NUM_CH gives rd_data <= 0.
  - The live value read is the value before this edge's increment.
- Live counters hold their value in IDLE and DONE. Snapshot registers change only on a perf_end capture or on clear.
- Reset mid-run aborts immediately to IDLE with everything zeroed. No partial snapshot is produced.

Decomposition:
- Shared package (perf_pkg): FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and mode constants (MODE_OFF, MODE_LEVEL, MODE_EDGE, MODE_RAW).
- One natural sub-module: perf_counter_ch, instantiated NUM_CH times via generate. It holds one live counter, its snapshot, prev and ovf, and takes clr, cap, run and mode inputs.
- The top level holds the FSM, gating and read mux.

Test Plan:
- Reset release, then read ch0 snapshot -> rd_data=0, busy=0, done=0, ovf=0.
- perf_start; ch0 mode 01 with event_in[0]=1 for 10 cycles, stall high on 3 of them; perf_end; read snapshot ch0 one cycle after rd_sel -> rd_data=7, done=1.
- ch1 mode 10; toggle event_in[1] to give 5 rising edges (one during stall), plus one edge coincident with perf_end -> snapshot ch1=4.
- CNT_W=8: run ch2 mode 11 for 260 cycles -> SATURATE=0 gives snapshot 4, ovf[2]=1; SATURATE=1 gives snapshot 255, ovf[2]=1.
- perf_start and perf_end asserted together while in DONE -> state RUN, snapshots and ovf cleared, busy=1 the next cycle.
- Assert rst mid-run with counters at 50 -> immediately all outputs 0 and state IDLE. A perf_end afterwards is ignored and done stays 0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared definitions for the performance event counter bank.
//   - perf_state_e : run-control FSM encoding (IDLE / RUN / DONE)
//   - MODE_*       : per-channel counting mode codes
//   - mode_inc()   : qualifies one channel's event for a single cycle
//                    according to its mode
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perf_state_e;

    localparam logic [1:0] MODE_OFF   = 2'b00;  // channel disabled
    localparam logic [1:0] MODE_LEVEL = 2'b01;  // count high cycles, frozen by stall
    localparam logic [1:0] MODE_EDGE  = 2'b10;  // count rising edges, frozen by stall
    localparam logic [1:0] MODE_RAW   = 2'b11;  // count high cycles, stall ignored

    // Per-mode event qualification. Run/enable gating is applied by the caller.
    function automatic logic mode_inc(
        input logic [1:0] mode,
        input logic       ev,
        input logic       prev,
        input logic       stall
    );
        logic hit;
        case (mode)
            MODE_OFF:   hit = 1'b0;
            MODE_LEVEL: hit = ev & ~stall;
            MODE_EDGE:  hit = ev & ~prev & ~stall;
            MODE_RAW:   hit = ev;
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/perf_event_counter_bank_if.sv
// Control, event and readout signals of the performance event counter bank.
//   master : the side that drives control/events and consumes readout
//   slave  : the counter bank itself
// Signals:
//   en, stall, perf_start, perf_end - global control
//   event_in[NUM_CH], ch_mode[2*NUM_CH] - per-channel events and modes
//   rd_sel, rd_live                 - readout select
//   rd_data, busy, done, ovf        - registered readout and status
interface perf_event_counter_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64,
    parameter int SEL_W  = 2
);
    logic                  en;
    logic                  stall;
    logic                  perf_start;
    logic                  perf_end;
    logic [NUM_CH-1:0]     event_in;
    logic [2*NUM_CH-1:0]   ch_mode;
    logic [SEL_W-1:0]      rd_sel;
    logic                  rd_live;
    logic [CNT_W-1:0]      rd_data;
    logic                  busy;
    logic                  done;
    logic [NUM_CH-1:0]     ovf;

    modport master (
        output en, stall, perf_start, perf_end, event_in, ch_mode, rd_sel, rd_live,
        input  rd_data, busy, done, ovf
    );

    modport slave (
        input  en, stall, perf_start, perf_end, event_in, ch_mode, rd_sel, rd_live,
        output rd_data, busy, done, ovf
    );
endinterface

// File: rtl/perf_counter_ch.sv
// One event counter channel: live counter, end-of-run snapshot, edge-detect
// history and sticky overflow flag.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - clear live, snapshot and overflow (start of run)
//   cap        - copy live into snapshot (end of run)
//   run        - counting window is open this cycle (RUN, enabled, no start/end)
//   mode       - counting mode (MODE_*)
//   stall      - pipeline freeze, gates level and edge modes
//   event_in   - this channel's event line
//   live, snap - current counter and last snapshot
//   ovf        - sticky overflow flag
module perf_counter_ch
    import perf_pkg::*;
#(
    parameter int CNT_W    = 64,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cap,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic             stall,
    input  logic             event_in,
    output logic [CNT_W-1:0] live,
    output logic [CNT_W-1:0] snap,
    output logic             ovf
);

    logic [CNT_W-1:0] live_r;
    logic [CNT_W-1:0] snap_r;
    logic             prev_r;
    logic             ovf_r;
    logic             inc_s;
    logic             all_ones_s;

    // Increment qualifier: mode rules apply only while the run window is open.
    always_comb begin
        inc_s = 1'b0;
        if (run) begin
            inc_s = mode_inc(mode, event_in, prev_r, stall);
        end else begin
            inc_s = 1'b0;
        end
    end

    assign all_ones_s = &live_r;

    // Counter, snapshot, edge history and overflow state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_r <= {CNT_W{1'b0}};
            snap_r <= {CNT_W{1'b0}};
            prev_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            // prev follows the event line in every state so that an edge
            // straddling a state change is judged against real history.
            prev_r <= event_in;
            if (clr) begin
                live_r <= {CNT_W{1'b0}};
                snap_r <= {CNT_W{1'b0}};
                ovf_r  <= 1'b0;
            end else begin
                if (cap) begin
                    snap_r <= live_r;
                end
                if (inc_s) begin
                    if (all_ones_s) begin
                        ovf_r <= 1'b1;
                        if (SATURATE != 0) begin
                            live_r <= live_r;
                        end else begin
                            live_r <= {CNT_W{1'b0}};
                        end
                    end else begin
                        live_r <= live_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

    assign live = live_r;
    assign snap = snap_r;
    assign ovf  = ovf_r;

endmodule

// File: rtl/perf_event_counter_bank.sv
// Multi-channel performance event counter bank. A shared IDLE/RUN/DONE
// controller opens a counting window on perf_start and captures per-channel
// snapshots on perf_end. One registered read port returns either a live
// counter or a snapshot for the selected channel.
// Ports:
//   clk  - clock (posedge)
//   rst  - asynchronous reset, active-high
//   bus  - slave side of perf_event_counter_bank_if (control, events,
//          modes, readout select, rd_data, busy, done, ovf)
module perf_event_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 64,
    parameter int SEL_W    = 2,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    perf_event_counter_bank_if.slave    bus
);

    perf_state_e      state_r;
    logic             clr_s;
    logic             cap_s;
    logic             run_s;
    logic [CNT_W-1:0] live_s [NUM_CH];
    logic [CNT_W-1:0] snap_s [NUM_CH];
    logic [CNT_W-1:0] rd_next_s;
    logic [CNT_W-1:0] rd_data_r;

    // Run-control FSM; perf_start has priority over perf_end from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            if (bus.perf_start) begin
                state_r <= RUN;
            end else if (bus.perf_end && (state_r == RUN)) begin
                state_r <= DONE;
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Channel control strobes. The start and end cycles never count.
    always_comb begin
        clr_s = bus.perf_start;
        cap_s = (state_r == RUN) && bus.perf_end && !bus.perf_start;
        run_s = (state_r == RUN) && bus.en && !bus.perf_start && !bus.perf_end;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_counter_ch #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr_s),
            .cap      (cap_s),
            .run      (run_s),
            .mode     (bus.ch_mode[2*i +: 2]),
            .stall    (bus.stall),
            .event_in (bus.event_in[i]),
            .live     (live_s[i]),
            .snap     (snap_s[i]),
            .ovf      (bus.ovf[i])
        );
    end

    // Read mux; an out-of-range select matches no channel and yields zero.
    always_comb begin
        rd_next_s = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            rd_next_s = (bus.rd_sel == SEL_W'(i))
                      ? (bus.rd_live ? live_s[i] : snap_s[i])
                      : rd_next_s;
        end
    end

    // Registered readout, one cycle after the select is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {CNT_W{1'b0}};
        end else begin
            rd_data_r <= rd_next_s;
        end
    end

    assign bus.rd_data = rd_data_r;
    assign bus.busy    = (state_r == RUN);
    assign bus.done    = (state_r == DONE);

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Self-checking bench: two 8-bit, 4-channel banks (wrap and saturate) share
// one stimulus stream and are checked against a count-based reference model.
module tb_perf_event_counter_bank;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int SW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, stall = 1'b0, perf_start = 1'b0, perf_end = 1'b0, rd_live = 1'b0;
    logic [NCH-1:0]   event_in = '0;
    logic [2*NCH-1:0] ch_mode = '0;
    logic [SW-1:0]    rd_sel = '0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    perf_event_counter_bank_if #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW)) if0 ();
    perf_event_counter_bank_if #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW)) if1 ();

    assign if0.en = en;         assign if1.en = en;
    assign if0.stall = stall;   assign if1.stall = stall;
    assign if0.perf_start = perf_start; assign if1.perf_start = perf_start;
    assign if0.perf_end = perf_end;     assign if1.perf_end = perf_end;
    assign if0.event_in = event_in;     assign if1.event_in = event_in;
    assign if0.ch_mode = ch_mode;       assign if1.ch_mode = ch_mode;
    assign if0.rd_sel = rd_sel;         assign if1.rd_sel = rd_sel;
    assign if0.rd_live = rd_live;       assign if1.rd_live = rd_live;

    perf_event_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0));
    perf_event_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1));

    // Index 0 = wrapping bank, index 1 = saturating bank.
    logic [CW-1:0]  rd_a   [2];
    logic           busy_a [2];
    logic           done_a [2];
    logic [NCH-1:0] ovf_a  [2];
    assign rd_a[0] = if0.rd_data; assign rd_a[1] = if1.rd_data;
    assign busy_a[0] = if0.busy;  assign busy_a[1] = if1.busy;
    assign done_a[0] = if0.done;  assign done_a[1] = if1.done;
    assign ovf_a[0] = if0.ovf;    assign ovf_a[1] = if1.ovf;

    // Reference model: unbounded event totals; the 8-bit view is derived.
    int            m_state;   // 0 idle, 1 run, 2 done
    int            tot [NCH];
    int            snt [NCH];
    bit            prv [NCH];
    logic [CW-1:0] exp_rd [2];

    function automatic logic [CW-1:0] view(input int t, input int sat);
        if (t <= 255) return 8'(t);
        else if (sat != 0) return 8'hFF;
        else return 8'(t % 256);
    endfunction

    function automatic logic [NCH-1:0] exp_ovf();
        logic [NCH-1:0] o = '0;
        for (int i = 0; i < NCH; i++) o[i] = (tot[i] >= 256);
        return o;
    endfunction

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < NCH; i++) begin tot[i] = 0; snt[i] = 0; prv[i] = 1'b0; end
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    // One clock: the model consumes the inputs seen at the edge, then outputs settle.
    task automatic tick();
        bit inc [NCH];
        int t;
        @(posedge clk);
        if (int'(rd_sel) < NCH) begin
            t = rd_live ? tot[rd_sel] : snt[rd_sel];
            exp_rd[0] = view(t, 0);
            exp_rd[1] = view(t, 1);
        end else begin
            exp_rd[0] = '0; exp_rd[1] = '0;
        end
        for (int i = 0; i < NCH; i++) begin
            inc[i] = 1'b0;
            if (m_state == 1 && en && !perf_start && !perf_end) begin
                case (ch_mode[2*i +: 2])
                    2'b01:   inc[i] = event_in[i] && !stall;
                    2'b10:   inc[i] = event_in[i] && !prv[i] && !stall;
                    2'b11:   inc[i] = event_in[i];
                    default: inc[i] = 1'b0;
                endcase
            end
        end
        if (perf_start) begin
            m_state = 1;
            for (int i = 0; i < NCH; i++) begin tot[i] = 0; snt[i] = 0; end
        end else if (perf_end && m_state == 1) begin
            m_state = 2;
            for (int i = 0; i < NCH; i++) snt[i] = tot[i];
        end else begin
            for (int i = 0; i < NCH; i++) if (inc[i]) tot[i]++;
        end
        for (int i = 0; i < NCH; i++) prv[i] = event_in[i];
        #1;
    endtask

    task automatic pulse_start();
        perf_start = 1'b1; tick(); perf_start = 1'b0;
    endtask

    task automatic pulse_end();
        perf_end = 1'b1; tick(); perf_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        rd_sel = 3'd0; rd_live = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rd_a[d] !== 8'd0 || busy_a[d] !== 1'b0 || done_a[d] !== 1'b0 || ovf_a[d] !== 4'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d: rd=%0d busy=%b done=%b ovf=%b, want 0/0/0/0",
                         d, rd_a[d], busy_a[d], done_a[d], ovf_a[d]);
            end
        end
    endtask

    task automatic test_level();
        en = 1'b1; ch_mode = 8'b0000_0001; event_in = '0;
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            event_in[0] = 1'b1;
            stall = (c == 2 || c == 5 || c == 8);
            tick();
        end
        event_in = '0; stall = 1'b0;
        pulse_end();
        rd_sel = 3'd0; rd_live = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rd_a[d] !== 8'd7 || done_a[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL level dut%0d: snap0=%0d done=%b, want 7/1", d, rd_a[d], done_a[d]);
            end
        end
    endtask

    task automatic test_edge();
        // {event_in[1], stall} per cycle: edges 1,2, a stalled edge, edges 3,4
        bit [1:0] pat [11] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11,
                               2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
        ch_mode = 8'b0000_1000; event_in = '0;
        pulse_start();
        foreach (pat[c]) begin
            event_in[1] = pat[c][1];
            stall = pat[c][0];
            tick();
        end
        stall = 1'b0;
        event_in[1] = 1'b1;       // rising edge on the perf_end cycle is discarded
        pulse_end();
        event_in = '0;
        rd_sel = 3'd1; rd_live = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rd_a[d] !== 8'd4) begin
                n_fail++;
                $display("FAIL edge dut%0d: snap1=%0d, want 4", d, rd_a[d]);
            end
        end
    endtask

    task automatic test_overflow();
        ch_mode = 8'b0011_0000; event_in = '0;
        pulse_start();
        event_in[2] = 1'b1;
        repeat (260) tick();
        pulse_end();
        event_in = '0;
        rd_sel = 3'd2; rd_live = 1'b0;
        tick();
        n_cmp++;
        if (rd_a[0] !== 8'd4 || ovf_a[0] !== 4'b0100) begin
            n_fail++;
            $display("FAIL ovf_wrap: snap2=%0d ovf=%b, want 4/0100", rd_a[0], ovf_a[0]);
        end
        n_cmp++;
        if (rd_a[1] !== 8'd255 || ovf_a[1] !== 4'b0100) begin
            n_fail++;
            $display("FAIL ovf_sat: snap2=%0d ovf=%b, want 255/0100", rd_a[1], ovf_a[1]);
        end
    endtask

    task automatic test_start_end_same();
        perf_start = 1'b1; perf_end = 1'b1;
        tick();
        perf_start = 1'b0; perf_end = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (busy_a[d] !== 1'b1 || done_a[d] !== 1'b0 || ovf_a[d] !== 4'd0) begin
                n_fail++;
                $display("FAIL start_end dut%0d: busy=%b done=%b ovf=%b, want 1/0/0000",
                         d, busy_a[d], done_a[d], ovf_a[d]);
            end
        end
        rd_sel = 3'd2; rd_live = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rd_a[d] !== 8'd0) begin
                n_fail++;
                $display("FAIL start_end_snap dut%0d: snap2=%0d, want 0", d, rd_a[d]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            en       = ($urandom_range(0, 9) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            event_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) ch_mode = 8'($urandom);
            rd_sel   = 3'($urandom_range(0, 5));
            rd_live  = 1'($urandom);
            perf_start = ($urandom_range(0, 79) == 0);
            perf_end   = ($urandom_range(0, 39) == 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (rd_a[d] !== exp_rd[d] || busy_a[d] !== (m_state == 1) ||
                    done_a[d] !== (m_state == 2) || ovf_a[d] !== exp_ovf()) begin
                    n_fail++;
                    $display("FAIL random c%0d dut%0d: rd=%0d busy=%b done=%b ovf=%b, want rd=%0d busy=%b done=%b ovf=%b",
                             c, d, rd_a[d], busy_a[d], done_a[d], ovf_a[d],
                             exp_rd[d], (m_state == 1), (m_state == 2), exp_ovf());
                end
            end
        end
        perf_start = 1'b0; perf_end = 1'b0; stall = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset_midrun();
        ch_mode = 8'b1100_0000; event_in = '0;
        pulse_start();
        event_in[3] = 1'b1;
        repeat (50) tick();
        event_in = '0;
        rd_sel = 3'd3; rd_live = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rd_a[d] !== 8'd50 || busy_a[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL live50 dut%0d: live3=%0d busy=%b, want 50/1", d, rd_a[d], busy_a[d]);
            end
        end
        rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rd_a[d] !== 8'd0 || busy_a[d] !== 1'b0 || done_a[d] !== 1'b0 || ovf_a[d] !== 4'd0) begin
                n_fail++;
                $display("FAIL midrun_rst dut%0d: rd=%0d busy=%b done=%b ovf=%b, want 0/0/0/0",
                         d, rd_a[d], busy_a[d], done_a[d], ovf_a[d]);
            end
        end
        #1 rst = 1'b0;
        rd_live = 1'b0;
        pulse_end();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (done_a[d] !== 1'b0 || busy_a[d] !== 1'b0 || rd_a[d] !== 8'd0) begin
                n_fail++;
                $display("FAIL end_after_rst dut%0d: done=%b busy=%b snap3=%0d, want 0/0/0",
                         d, done_a[d], busy_a[d], rd_a[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_overflow();
        test_start_end_same();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
